// File: rtl/task2_15_gate_if.sv
// Operand/result bundle for task2_15_gate: two 1-bit operands in, registered result
// and saturating transition count out.
interface task2_15_gate_if #(
    parameter int CNT_W = 8
);
    logic             in1;
    logic             in2;
    logic             out;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output in1,
        output in2,
        input  out,
        input  toggle_cnt
    );

    modport slave (
        input  in1,
        input  in2,
        output out,
        output toggle_cnt
    );
endinterface

// File: rtl/task2_15_gate.sv
// Registered two-input gate with selectable Boolean function and saturating output-toggle counter.
// Define TASK2_15_SYNC_EN to insert a 2-flop synchronizer on each operand (latency 3 instead of 1).
module task2_15_gate #(
    parameter int FUNC  = 2,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    task2_15_gate_if.slave bus
);

    if (FUNC < 0 || FUNC > 7) begin : g_bad_func
        $error("task2_15_gate: FUNC=%0d is outside 0..7", FUNC);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("task2_15_gate: CNT_W=%0d is outside 1..32", CNT_W);
    end

    function automatic logic eval_func(input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (FUNC)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            3:       r = ~(a & b);
            4:       r = ~(a | b);
            5:       r = ~(a ^ b);
            6:       r = a & ~b;
            7:       r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic a_p1;
    logic b_p1;

`ifdef TASK2_15_SYNC_EN
    logic in1_p0;
    logic in2_p0;
    logic in1_p1;
    logic in2_p1;

    // Synchronizer stages: p0 may go metastable, p1 is the settled copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            in1_p0 <= 1'b0;
            in2_p0 <= 1'b0;
            in1_p1 <= 1'b0;
            in2_p1 <= 1'b0;
        end else begin
            in1_p0 <= bus.in1;
            in2_p0 <= bus.in2;
            in1_p1 <= in1_p0;
            in2_p1 <= in2_p0;
        end
    end

    assign a_p1 = in1_p1;
    assign b_p1 = in2_p1;
`else
    assign a_p1 = bus.in1;
    assign b_p1 = bus.in2;
`endif

    logic             res_p1;
    logic             out_p2;
    logic [CNT_W-1:0] cnt_p2;

    assign res_p1 = eval_func(a_p1, b_p1);

    // Output register: the counter compares the incoming result against the held output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p2 <= 1'b0;
            cnt_p2 <= '0;
        end else begin
            out_p2 <= res_p1;
            if (res_p1 != out_p2) begin
                cnt_p2 <= sat_inc(cnt_p2);
            end
        end
    end

    assign bus.out        = out_p2;
    assign bus.toggle_cnt = cnt_p2;

endmodule

// File: tb/tb_task2_15_gate.sv
// Directed bench for task2_15_gate: one instance per FUNC plus a 2-bit-counter instance.
// Works with or without TASK2_15_SYNC_EN; operand steps are held for the configured latency.
module tb_task2_15_gate;

`ifdef TASK2_15_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in1 = 1'b0;
    logic in2 = 1'b0;

    logic [7:0]  outs;
    logic [7:0]  cnts [8];
    logic        out_sat;
    logic [1:0]  cnt_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar f = 0; f < 8; f++) begin : g_fn
        task2_15_gate_if #(.CNT_W(8)) bus ();
        assign bus.in1 = in1;
        assign bus.in2 = in2;
        task2_15_gate #(.FUNC(f), .CNT_W(8)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign outs[f] = bus.out;
        assign cnts[f] = bus.toggle_cnt;
    end

    task2_15_gate_if #(.CNT_W(2)) bus_sat ();
    assign bus_sat.in1 = in1;
    assign bus_sat.in2 = in2;
    task2_15_gate #(.FUNC(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );
    assign out_sat = bus_sat.out;
    assign cnt_sat = bus_sat.toggle_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic a, input logic b);
        in1 = a;
        in2 = b;
        repeat (LAT) step();
    endtask

    logic [3:0] tt      [8];
    logic [7:0] tt_cnt  [8];
    logic [3:0] xor_exp;

    initial begin
        // truth tables indexed by {in1,in2}
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
        // toggles seen over the sweep 00,01,10,11 starting from out=0
        tt_cnt[0] = 8'd1; tt_cnt[1] = 8'd1; tt_cnt[2] = 8'd2; tt_cnt[3] = 8'd2;
        tt_cnt[4] = 8'd2; tt_cnt[5] = 8'd3; tt_cnt[6] = 8'd2; tt_cnt[7] = 8'd1;
        xor_exp = 4'b0110;

        // reset held with both operands high
        rst = 1'b1;
        in1 = 1'b1;
        in2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out", 32'(outs[2]), 32'd0);
            chk("rst_cnt", 32'(cnts[2]), 32'd0);
        end
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("rst_out_f%0d", f), 32'(outs[f]), 32'd0);
        end
        chk("rst_cnt_sat", 32'(cnt_sat), 32'd0);
        rst = 1'b0;

        // truth-table sweep across every function
        for (int p = 0; p < 4; p++) begin
            apply(p[1], p[0]);
            chk($sformatf("xor_tt_p%0d", p), 32'(outs[2]), 32'(xor_exp[p]));
            for (int f = 0; f < 8; f++) begin
                chk($sformatf("sweep_f%0d_p%0d", f, p), 32'(outs[f]), 32'(tt[f][p]));
            end
        end
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("sweep_cnt_f%0d", f), 32'(cnts[f]), 32'(tt_cnt[f]));
        end
        chk("sweep_cnt_sat", 32'(cnt_sat), 32'd2);

        // saturation on the 2-bit counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("sat_cleared", 32'(cnt_sat), 32'd0);
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("sat_out_%0d", i), 32'(out_sat), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("sat_cnt_%0d", i), 32'(cnt_sat), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // mid-operation reset with out=1, toggle_cnt=5
        rst = 1'b1;
        step();
        rst = 1'b0;
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        apply(1'b0, 1'b1);
        chk("mid_pre_out", 32'(outs[2]), 32'd1);
        chk("mid_pre_cnt", 32'(cnts[2]), 32'd5);
        in1 = 1'b1;
        in2 = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_out", 32'(outs[2]), 32'd0);
        chk("mid_rst_cnt", 32'(cnts[2]), 32'd0);
        rst = 1'b0;
        repeat (LAT) step();
        chk("mid_post_out", 32'(outs[2]), 32'd1);
        chk("mid_post_cnt", 32'(cnts[2]), 32'd1);

        // latency of a single 0->1 step on in1
        in1 = 1'b0;
        in2 = 1'b0;
        repeat (3) step();
        chk("lat_base", 32'(outs[2]), 32'd0);
        in1 = 1'b1;
        step();
`ifdef TASK2_15_SYNC_EN
        chk("lat_k", 32'(outs[2]), 32'd0);
        step();
        chk("lat_k1", 32'(outs[2]), 32'd0);
        step();
        chk("lat_k2", 32'(outs[2]), 32'd1);
        chk("lat_k2_pass", 32'(outs[7]), 32'd1);
`else
        chk("lat_k", 32'(outs[2]), 32'd1);
        chk("lat_k_pass", 32'(outs[7]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/task2_15_gate.md
# task2_15_gate

Registered two-input logic gate with configurable Boolean function and an output-transition counter. It is used wherever a single clocked combinational decision on two 1-bit control signals is needed, giving a glitch-free, clock-aligned `out`. An optional input synchronizer allows it to accept asynchronous inputs.

## Interface
- `FUNC`, default 2: selects the Boolean function. 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 in1 AND NOT in2, 7 in1 pass-through.
- `CNT_W`, default 8: width of the transition counter, legal range 1..32.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in1`  input  1  operand A.
- `in2`  input  1  operand B.
- `out`  output  1  registered result of `FUNC(in1, in2)`.
- `toggle_cnt`  output  CNT_W  saturating count of `out` value changes since reset.

## Operation
- Each rising edge of `clk` with `rst` low:
  - the function result of the sampled operands is loaded into `out`;
  - if the new `out` differs from the current `out`, `toggle_cnt` increments by 1.
- `toggle_cnt` saturates at 2^CNT_W−1. It never wraps.
- An illegal `FUNC` (greater than 7) is a configuration error. The RTL must flag it at elaboration, using a generate-time `$error` or equivalent.
- Reset:
  - `rst` is sampled on the rising edge only.
  - While `rst` is high: `out` = 0, `toggle_cnt` = 0, and all internal synchronizer flops = 0.
  - Reset takes priority over any concurrent update, including a pending transition.
  - The transition from the reset value 0 to a first result of 1 counts as a toggle.
- `in1`/`in2` changing exactly at the clock edge are treated per normal setup/hold. When `TASK2_15_SYNC_EN` is defined, asynchronous inputs are legal.
- There is no enable or handshake. The block evaluates every cycle.

## Timing
- Without sync: 1-cycle latency. Inputs present before edge k appear on `out` after edge k.
- With sync: 3-cycle latency, consisting of 2 synchronizer stages plus the output register.
- `toggle_cnt` updates on the same edge as the `out` change it counts.
- First valid `out` after reset deassertion:
  - without sync: edge 1 after `rst` falls;
  - with sync: edge 3 after `rst` falls. Until then `out` holds 0, because the synchronizer flops were cleared.
- Both outputs come directly from flops, with no combinational path from the inputs.

## Configuration
- `TASK2_15_SYNC_EN`:
  - Defined: each of `in1` and `in2` passes through a 2-flop synchronizer, reset to 0, before function evaluation. Latency is 3 cycles.
  - Undefined: inputs feed the function logic directly. Latency is 1 cycle, and the inputs must be synchronous to `clk`.

## Test plan
- Reset:
  - Hold `rst`=1 for 3 cycles with in1=in2=1 → `out`=0 and `toggle_cnt`=0 throughout.
- Truth table, default FUNC=2, no sync:
  - Drive (in1,in2) = 00, 01, 10, 11, each for 1 cycle.
  - Required `out` one edge later: 0, 1, 1, 0.
  - Final `toggle_cnt` = 2.
- All functions:
  - Sweep FUNC 0..7 across the four input pairs and compare against the table in Interface.
  - Example: FUNC=3 with in1=in2=1 → `out`=0; with 00 → `out`=1.
- Saturation:
  - With CNT_W=2 and FUNC=2, alternate in2 0/1 every cycle with in1=0 for 6 cycles.
  - `toggle_cnt` must reach 3 and hold at 3.
- Mid-operation reset:
  - Assert `rst` for 1 cycle at a point where `out`=1 and `toggle_cnt`=5.
  - After that edge, `out`=0 and `toggle_cnt`=0.
  - With in1=1, in2=0 held, the next edge gives `out`=1 and `toggle_cnt`=1.
- Sync latency (`TASK2_15_SYNC_EN` defined):
  - Step in1 from 0 to 1 with in2=0 one cycle before edge k.
  - `out` must be 0 after edges k and k+1, and 1 after edge k+2.
